// File: rtl/spi_frame_fsm.sv
// SPI slave frame sequencer: address, R/W decision and data phases.
// Define SPI_FSM_BURST_EN for burst frames with address auto-increment.
module spi_frame_fsm #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic cs,
  input  logic sout,
  output logic miso_buff,
  output logic dm_we,
  output logic addr_we,
  output logic sr_we,
  output logic addr_inc,
  output logic busy,
  output logic done,
  output logic abort
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);
`ifdef SPI_FSM_BURST_EN
  localparam logic [CNT_W-1:0] D_PRE  = CNT_W'(DATA_W - 2);
`endif

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] COMMIT = 3'd3;
  localparam logic [2:0] LOAD   = 3'd4;
  localparam logic [2:0] READ   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic miso_q, miso_d;
  logic dm_we_q, dm_we_d;
  logic addr_we_q, addr_we_d;
  logic sr_we_q, sr_we_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic abort_q, abort_d;
`ifdef SPI_FSM_BURST_EN
  logic inc_q, inc_d;
`endif

  always_comb begin
    state_d   = IDLE;
    cnt_d     = '0;
    miso_d    = 1'b0;
    dm_we_d   = 1'b0;
    addr_we_d = 1'b0;
    sr_we_d   = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
`ifdef SPI_FSM_BURST_EN
    inc_d     = 1'b0;
`endif
    if (cs) begin
      // a word is only lost if data bits were already in flight
      abort_d = (state_q == ADDR) || (state_q == READ) ||
                ((state_q == WRITE) && (cnt_q != '0));
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = ADDR;
          addr_we_d = 1'b1;
        end
        ADDR: begin
          if (cnt_q == A_LAST) begin
            state_d = sout ? LOAD : WRITE;
            sr_we_d = sout;
          end else begin
            state_d   = ADDR;
            cnt_d     = cnt_q + 1'b1;
            addr_we_d = 1'b1;
          end
        end
        WRITE: begin
          if (cnt_q == D_LAST) begin
            state_d = COMMIT;
            dm_we_d = 1'b1;
            done_d  = 1'b1;
`ifdef SPI_FSM_BURST_EN
            inc_d   = 1'b1;
`endif
          end else begin
            state_d = WRITE;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        COMMIT: begin
`ifdef SPI_FSM_BURST_EN
          state_d = WRITE;
`else
          state_d = IDLE;
`endif
        end
        LOAD: begin
          state_d = READ;
          miso_d  = 1'b1;
        end
        READ: begin
          if (cnt_q == D_LAST) begin
            done_d = 1'b1;
`ifdef SPI_FSM_BURST_EN
            state_d = LOAD;
            sr_we_d = 1'b1;
`else
            state_d = IDLE;
`endif
          end else begin
            state_d = READ;
            cnt_d   = cnt_q + 1'b1;
            miso_d  = 1'b1;
`ifdef SPI_FSM_BURST_EN
            inc_d   = (cnt_q == D_PRE);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      miso_q    <= 1'b0;
      dm_we_q   <= 1'b0;
      addr_we_q <= 1'b0;
      sr_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      miso_q    <= miso_d;
      dm_we_q   <= dm_we_d;
      addr_we_q <= addr_we_d;
      sr_we_q   <= sr_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

`ifdef SPI_FSM_BURST_EN
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) inc_q <= 1'b0;
    else        inc_q <= inc_d;
  end
  assign addr_inc = inc_q;
`else
  assign addr_inc = 1'b0;
`endif

  assign miso_buff = miso_q;
  assign dm_we     = dm_we_q;
  assign addr_we   = addr_we_q;
  assign sr_we     = sr_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_spi_frame_fsm.sv
// Bench for spi_frame_fsm: cycle-position reference model, random frames.
// Output vector order: miso_buff dm_we addr_we sr_we addr_inc busy done abort.
module tb_spi_frame_fsm;

  localparam int A = 7;
  localparam int D = 8;
  localparam int P = A + D + 2;

  logic sclk = 1'b0;
  logic rst_n, cs, sout;
  logic miso_buff, dm_we, addr_we, sr_we, addr_inc, busy, done, abort;
  logic [7:0] outs;

  int tests = 0;
  int fails = 0;

  logic [7:0] obs_a [0:127];
  logic [7:0] exp_a [0:127];

  spi_frame_fsm #(.ADDR_W(A), .DATA_W(D)) dut (
    .sclk(sclk), .rst_n(rst_n), .cs(cs), .sout(sout),
    .miso_buff(miso_buff), .dm_we(dm_we), .addr_we(addr_we),
    .sr_we(sr_we), .addr_inc(addr_inc), .busy(busy),
    .done(done), .abort(abort)
  );

  always #5 sclk = ~sclk;

  assign outs = {miso_buff, dm_we, addr_we, sr_we,
                 addr_inc, busy, done, abort};

`ifdef SPI_FSM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // {abortable, outputs} at cycle p of a frame with cs held low throughout
  function automatic logic [8:0] pos_out(input bit rd, input int p);
    logic m, dw, aw, sw, ai, bz, dn, ab;
    int q, r;
    {m, dw, aw, sw, ai, bz, dn, ab} = '0;
    if (!BURST) begin
      q  = (p - 1) % P + 1;
      aw = (q <= A);
      if (!rd) begin
        bz = (q <= A + D + 1);
        dw = (q == A + D + 1);
        dn = dw;
        ab = (q <= A) || (q > A + 1 && q <= A + D);
      end else begin
        bz = (q <= A + D + 1);
        sw = (q == A + 1);
        m  = (q >= A + 2) && (q <= A + D + 1);
        dn = (q == A + D + 2);
        ab = (q <= A) || m;
      end
    end else begin
      bz = 1'b1;
      if (p <= A) begin
        aw = 1'b1;
        ab = 1'b1;
      end else begin
        r = (p - A - 1) % (D + 1);
        if (!rd) begin
          dw = (r == D);
          dn = dw;
          ai = dw;
          ab = (r >= 1) && (r <= D - 1);
        end else begin
          sw = (r == 0);
          m  = (r >= 1);
          ai = (r == D);
          dn = (r == 0) && (p > A + 1);
          ab = (r >= 1);
        end
      end
    end
    return {ab, m, dw, aw, sw, ai, bz, dn, 1'b0};
  endfunction

  // expected outputs at cycle c when cs is first sampled high at edge e
  function automatic logic [7:0] model(input bit rd, input int e,
                                       input int c);
    logic [8:0] v;
    if (c <= e) begin
      v = pos_out(rd, c);
      return v[7:0];
    end
    if (c == e + 1) begin
      v = pos_out(rd, e);
      return {7'b0, v[8]};
    end
    return 8'h00;
  endfunction

  function automatic bit is_decision(input int k);
    if (BURST) return (k == A);
    return ((k % P) == A);
  endfunction

  // starts at a negedge with the DUT idle; cs low for edges 0..e-1
  task automatic run_frame(input bit rd, input int e, output int n);
    n = e + 2;
    for (int k = 0; k <= e + 1; k++) begin
      cs   = (k >= e);
      sout = is_decision(k) ? rd : 1'($urandom_range(0, 1));
      @(posedge sclk);
      @(negedge sclk);
      obs_a[k+1] = outs;
      exp_a[k+1] = model(rd, e, k + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    cs    = 1'b1;
    sout  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    tests++;
    if (outs !== 8'h00) begin
      fails++;
      $display("FAIL reset_hold: got %b, want 00000000", outs);
    end
    rst_n = 1'b1;
    cs    = 1'b0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    tests++;
    if (addr_we !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_addr_phase: addr_we=%b busy=%b, want 1 1",
               addr_we, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (outs !== 8'h00) begin
      fails++;
      $display("FAIL reset_async: got %b, want 00000000", outs);
    end
    cs = 1'b1;
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    tests++;
    if (outs !== 8'h00) begin
      fails++;
      $display("FAIL reset_release: got %b, want 00000000", outs);
    end
  endtask

  task automatic test_write();
    int n;
    run_frame(1'b0, 17, n);
    for (int c = 1; c <= n; c++) begin
      tests++;
      if (obs_a[c] !== exp_a[c]) begin
        fails++;
        $display("FAIL write c%0d: got %b, want %b", c, obs_a[c], exp_a[c]);
      end
    end
    tests++;
    if (obs_a[16][6] !== 1'b1 || obs_a[16][1] !== 1'b1) begin
      fails++;
      $display("FAIL write_commit: got %b, want dm_we=done=1", obs_a[16]);
    end
  endtask

  task automatic test_read();
    int n;
    run_frame(1'b1, 17, n);
    for (int c = 1; c <= n; c++) begin
      tests++;
      if (obs_a[c] !== exp_a[c]) begin
        fails++;
        $display("FAIL read c%0d: got %b, want %b", c, obs_a[c], exp_a[c]);
      end
      tests++;
      if (obs_a[c][6] !== 1'b0) begin
        fails++;
        $display("FAIL read_no_dm_we c%0d: got 1, want 0", c);
      end
    end
  endtask

  task automatic test_abort();
    int n, cnt;
    cnt = 0;
    run_frame(1'b0, 11, n);
    for (int c = 1; c <= n; c++) begin
      tests++;
      if (obs_a[c] !== exp_a[c]) begin
        fails++;
        $display("FAIL abort c%0d: got %b, want %b", c, obs_a[c], exp_a[c]);
      end
      cnt += int'(obs_a[c][0]);
    end
    tests++;
    if (obs_a[12][0] !== 1'b1 || cnt != 1) begin
      fails++;
      $display("FAIL abort_pulse: abort@12=%b count=%0d, want 1 1",
               obs_a[12][0], cnt);
    end
  endtask

  task automatic test_burst_write();
    int n, dn;
    dn = 0;
    run_frame(1'b0, 34, n);
    for (int c = 1; c <= n; c++) begin
      tests++;
      if (obs_a[c] !== exp_a[c]) begin
        fails++;
        $display("FAIL burst_write c%0d: got %b, want %b",
                 c, obs_a[c], exp_a[c]);
      end
      dn += int'(obs_a[c][1]);
    end
    tests++;
    if (dn != (BURST ? 3 : 2) || obs_a[35][0] !== 1'b0) begin
      fails++;
      $display("FAIL burst_write_done: done=%0d abort=%b, want %0d 0",
               dn, obs_a[35][0], BURST ? 3 : 2);
    end
  endtask

  task automatic test_burst_read();
    int n;
    run_frame(1'b1, 26, n);
    for (int c = 1; c <= n; c++) begin
      tests++;
      if (obs_a[c] !== exp_a[c]) begin
        fails++;
        $display("FAIL burst_read c%0d: got %b, want %b",
                 c, obs_a[c], exp_a[c]);
      end
    end
  endtask

  task automatic test_random();
    int n, e;
    bit rd;
    for (int i = 0; i < 20; i++) begin
      rd = 1'($urandom_range(0, 1));
      e  = int'($urandom_range(1, 60));
      run_frame(rd, e, n);
      for (int c = 1; c <= n; c++) begin
        tests++;
        if (obs_a[c] !== exp_a[c]) begin
          fails++;
          $display("FAIL random%0d rd=%0d e=%0d c%0d: got %b, want %b",
                   i, rd, e, c, obs_a[c], exp_a[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_burst_write();
    test_burst_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_frame_fsm.md
# spi_frame_fsm

Parametrised SPI slave frame controller, the next generation of the lab's fixed 7-bit-address / 8-bit-data SPI FSM. Sits between the SPI input synchroniser/shift register and the data memory. It sequences the address, R/W and data phases of each frame and drives the address latch, data-memory and shift-register write enables and the MISO buffer. New in this generation:

- configurable address and data widths;
- asynchronous reset;
- completion and abort status pulses;
- optional burst mode with address auto-increment.

## Interface

Parameters:

- ADDR_W, 7, address phase length in sclk cycles (≥2)
- DATA_W, 8, data phase length in sclk cycles (≥2)
- CNT_W is a localparam: clog2 of max(ADDR_W, DATA_W)+1.

Ports:

- sclk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- cs  in  1  chip select, active-low (1 = deselected)
- sout  in  1  shift-register serial out; carries the R/W bit (1 = read) at the decision edge
- miso_buff  out  1  enables the MISO tristate buffer
- dm_we  out  1  data-memory write enable
- addr_we  out  1  address latch write enable
- sr_we  out  1  shift-register parallel load enable
- addr_inc  out  1  address latch increment (burst only)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse per completed word
- abort  out  1  one-cycle pulse when a frame is cut short by cs

## Operation

- All outputs are registered.
- While rst_n=0: state=IDLE, cnt=0, and every output is 0.
- Priority at each edge: rst_n, then cs=1, then state logic.
- Any edge sampling cs=1:
  - next state is IDLE, cnt=0, and all outputs are 0 except abort;
  - abort=1 if the current state is ADDR, READ, or WRITE with cnt≠0; otherwise abort=0.
- IDLE with cs=0:
  - next state ADDR, cnt=0;
  - addr_we=1, busy=1.
- ADDR with cnt<ADDR_W-1: cnt+1, addr_we stays 1.
- ADDR with cnt=ADDR_W-1 (decision edge): addr_we=0, cnt=0.
  - sout=0: next state WRITE.
  - sout=1: next state LOAD, sr_we=1.
- WRITE with cnt<DATA_W-1: cnt+1.
- WRITE with cnt=DATA_W-1: next state COMMIT, dm_we=1, done=1.
- COMMIT: dm_we=0, done=0.
  - Without burst: next state IDLE.
  - With burst: next state WRITE with cnt=0; addr_inc is asserted in the COMMIT cycle itself, concurrent with dm_we (the memory writes at the old address, the latch increments on the same edge).
- LOAD: sr_we=0, next state READ with cnt=0, miso_buff=1.
- READ with cnt<DATA_W-1: cnt+1, miso_buff stays 1.
  - With burst, addr_inc=1 during the cycle in which cnt=DATA_W-1.
- READ with cnt=DATA_W-1: miso_buff=0, done=1.
  - Without burst: next state IDLE.
  - With burst: next state LOAD, sr_we=1.
- Outputs not named in a transition are 0 in the next cycle.
- The state register is fully decoded. Any unused encoding returns to IDLE on the next edge with all outputs 0.

## Timing

- Cycle n is the sclk period after edge n-1. Edge 0 is the first edge sampling cs=0 in IDLE.
- Address phase: addr_we is high in cycles 1..ADDR_W. The decision edge is edge ADDR_W.
- Write frame:
  - data bits span cycles ADDR_W+1 .. ADDR_W+DATA_W;
  - dm_we and done are high in cycle ADDR_W+DATA_W+1.
- Read frame:
  - sr_we is high in cycle ADDR_W+1;
  - miso_buff is high in cycles ADDR_W+2 .. ADDR_W+DATA_W+1;
  - done is high in cycle ADDR_W+DATA_W+2.
- Burst: each additional word costs DATA_W+1 cycles, including one gap cycle (COMMIT or LOAD).
- Without burst, if cs stays low after a frame, IDLE starts a new address phase on the next edge.
- rst_n asserted mid-frame clears all outputs immediately, with no done or abort.

## Configuration

- SPI_FSM_BURST_EN defined:
  - COMMIT loops back to WRITE and READ loops back to LOAD while cs=0;
  - addr_inc is driven as described in Operation.
- SPI_FSM_BURST_EN undefined:
  - COMMIT and the end of READ return to IDLE;
  - addr_inc is tied to 0;
  - addr_inc logic is not compiled.

## Test plan

All scenarios use ADDR_W=7, DATA_W=8.

- Reset: rst_n=0 mid-ADDR, asynchronously between edges -> all outputs 0 at once; state IDLE after release.
- Write: cs=0, sout=0 at edge 7 -> addr_we high cycles 1-7; dm_we=done=1 only in cycle 16; busy=0 from cycle 17.
- Read: sout=1 at edge 7 -> sr_we high cycle 8; miso_buff high cycles 9-16; done high cycle 17; no dm_we.
- Abort: cs=1 sampled at edge 11 during WRITE -> abort=1 for exactly one cycle (12); dm_we never high; IDLE.
- Burst, SPI_FSM_BURST_EN defined, write with cs low for 3 words -> dm_we and addr_inc high in cycles 16, 25 and 34; done pulses 3 times. Raising cs at edge 34 (state COMMIT) -> abort=0.
- Burst read, SPI_FSM_BURST_EN defined -> addr_inc high cycle 16; sr_we high cycles 8 and 17; miso_buff high cycles 9-16 and 18-25.
